// File: rtl/dino_pkg.sv
// Shared types and screen constants for the dinosaur sprite responder.
package dino_pkg;
   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int SPR_FRAMES = 4;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [1:0] anim;
   } sprite_pos_t;
endpackage

// File: rtl/dino_sprite_rom.sv
// Combinational bitmap ROM: four animation frames of the dinosaur.
// Frames differ only in leg length; out-of-range row/col reads 0.
module dino_sprite_rom #(
   parameter int SPR_W = 32,
   parameter int SPR_H = 32
) (
   input  logic [1:0] anim,
   input  logic [5:0] row,
   input  logic [5:0] col,
   output logic       pix
);
   logic       head, body, tail, legs;
   logic [5:0] la_end, lb_end;

   always_comb begin
      la_end = 6'd31;
      lb_end = 6'd31;
      case (anim)
         2'd0: begin la_end = 6'd31; lb_end = 6'd31; end
         2'd1: begin la_end = 6'd31; lb_end = 6'd25; end
         2'd2: begin la_end = 6'd25; lb_end = 6'd31; end
         default: begin la_end = 6'd23; lb_end = 6'd23; end
      endcase

      head = (row <= 6'd7) && (col inside {[6'd16:6'd31]}) &&
             !((row inside {[6'd2:6'd3]}) && (col inside {[6'd20:6'd21]}));
      body = (row inside {[6'd8:6'd21]}) && (col inside {[6'd4:6'd23]});
      tail = (row inside {[6'd10:6'd13]}) && (col <= 6'd3);
      legs = (row >= 6'd22) &&
             (((col inside {[6'd8:6'd11]})  && (row <= la_end)) ||
              ((col inside {[6'd16:6'd19]}) && (row <= lb_end)));

      pix = 1'b0;
      if ((int'(row) < SPR_H) && (int'(col) < SPR_W))
         pix = head | body | tail | legs;
   end
endmodule

// File: rtl/dino_sprite.sv
// Dinosaur sprite pixel responder with shadow/live registers committed on vs fall.
// Optional horizontal flip input enabled by DINO_SPRITE_MIRROR_EN.
module dino_sprite
   import dino_pkg::*;
#(
   parameter int         SPR_W  = 32,
   parameter int         SPR_H  = 32,
   parameter logic [9:0] INIT_X = 10'd64,
   parameter logic [8:0] INIT_Y = 9'd400
) (
   input  logic       vga_clk,
   input  logic       clrn,
   input  logic [8:0] row_addr,
   input  logic [9:0] col_addr,
   input  logic       rdn,
   input  logic       vs,
   input  logic [9:0] pos_x,
   input  logic [8:0] pos_y,
   input  logic [1:0] anim,
`ifdef DINO_SPRITE_MIRROR_EN
   input  logic       mirror,
`endif
   input  logic       pos_we,
   output logic       upd_pending,
   output logic       frame_start,
   output logic       px_dinosaur
);
   localparam sprite_pos_t INIT_POS = '{x: INIT_X, y: INIT_Y, anim: 2'd0};

   sprite_pos_t shadow, live;
   logic        vs_d, vs_fall;
   logic [9:0]  cx, dx;
   logic [8:0]  dy;
   logic [5:0]  rom_col;
   logic        hit, rom_bit;

   assign vs_fall = vs_d & ~vs;

   // Evaluate one column ahead so the registered pixel lines up with col_addr.
   assign cx  = col_addr + 10'd1;
   assign dx  = cx - live.x;
   assign dy  = row_addr - live.y;
   assign hit = (dx < 10'(SPR_W)) && (dy < 9'(SPR_H));

`ifdef DINO_SPRITE_MIRROR_EN
   logic shadow_mirror, live_mirror;

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         shadow_mirror <= 1'b0;
         live_mirror   <= 1'b0;
      end else begin
         if (vs_fall) live_mirror   <= shadow_mirror;
         if (pos_we)  shadow_mirror <= mirror;
      end
   end

   assign rom_col = live_mirror ? (6'(SPR_W - 1) - dx[5:0]) : dx[5:0];
`else
   assign rom_col = dx[5:0];
`endif

   dino_sprite_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
      .anim (live.anim),
      .row  (dy[5:0]),
      .col  (rom_col),
      .pix  (rom_bit)
   );

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         vs_d        <= 1'b1;
         shadow      <= INIT_POS;
         live        <= INIT_POS;
         upd_pending <= 1'b0;
         frame_start <= 1'b0;
         px_dinosaur <= 1'b0;
      end else begin
         vs_d        <= vs;
         frame_start <= vs_fall;
         // Commit reads the pre-write shadow, so a same-cycle write waits a frame.
         if (vs_fall) live <= shadow;
         if (pos_we) begin
            shadow      <= '{x: pos_x, y: pos_y, anim: anim};
            upd_pending <= 1'b1;
         end else if (vs_fall) begin
            upd_pending <= 1'b0;
         end
         px_dinosaur <= ~rdn & hit & rom_bit;
      end
   end
endmodule
